// File: rtl/hsv2rgb_clk.sv
// hsv2rgb_clk - multi-cycle HSV to RGB converter for the cube-colour pipeline.
//
// One pixel is accepted on an `enable` strobe while idle. The three channel
// values p, q and t are produced by a single shared 8-step restoring divider
// against the constant divisor DIVK = 255*30, and the result is presented on
// RGB24 with a one-cycle rgb_done pulse 26 cycles after the accept edge.
//
// Optional build macro: HSV2RGB_ROUND_EN
//   defined   -> each numerator is biased by DIVK/2 (round half up)
//   undefined -> plain truncation (floor)
// Latency and interface are identical in both builds.
module hsv2rgb_clk (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [23:0] HSV24,
    output logic [23:0] RGB24,
    output logic        rgb_done,
    output logic        busy
);

    localparam int unsigned DIVK    = 7650;
    localparam logic [15:0] DIVK_16 = 16'(DIVK);
    localparam logic [20:0] DIVK_21 = 21'(DIVK);
`ifdef HSV2RGB_ROUND_EN
    localparam logic [20:0] BIAS    = 21'(DIVK / 2);
`else
    localparam logic [20:0] BIAS    = 21'd0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DIV  = 2'd2,
        S_MAP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t      state_reg,  state_next;
    logic [7:0]  h_reg,      h_next;       // hue already wrapped into 0..179
    logic [7:0]  s_reg,      s_next;
    logic [7:0]  v_reg,      v_next;
    logic [2:0]  sector_reg, sector_next;
    logic [20:0] num_reg     [3];          // numerators for p, q, t
    logic [20:0] num_next    [3];
    logic [20:0] rem_reg,    rem_next;     // divider partial remainder
    logic [7:0]  quot_reg,   quot_next;    // divider partial quotient
    logic [7:0]  res_reg     [3];          // finished quotients p, q, t
    logic [7:0]  res_next    [3];
    logic [1:0]  ch_reg,     ch_next;      // which numerator is being divided
    logic [2:0]  step_reg,   step_next;    // current quotient bit (7 down to 0)
    logic [23:0] rgb_reg,    rgb_next;
    logic        done_reg,   done_next;

    // ------------------------------------------------------------------
    // Sector / fractional split of the registered hue
    // ------------------------------------------------------------------
    logic [2:0] sec_w;
    logic [7:0] base_w;
    logic [7:0] f_w;
    logic [7:0] k_w     [3];
    logic [20:0] num_w  [3];

    // Hue sector lookup by comparison ladder; h_reg is always below 180.
    always_comb begin
        sec_w  = 3'd0;
        base_w = 8'd0;
        if (h_reg >= 8'd150) begin
            sec_w  = 3'd5;
            base_w = 8'd150;
        end else if (h_reg >= 8'd120) begin
            sec_w  = 3'd4;
            base_w = 8'd120;
        end else if (h_reg >= 8'd90) begin
            sec_w  = 3'd3;
            base_w = 8'd90;
        end else if (h_reg >= 8'd60) begin
            sec_w  = 3'd2;
            base_w = 8'd60;
        end else if (h_reg >= 8'd30) begin
            sec_w  = 3'd1;
            base_w = 8'd30;
        end
    end

    assign f_w    = h_reg - base_w;
    assign k_w[0] = 8'd30;            // p
    assign k_w[1] = f_w;              // q
    assign k_w[2] = 8'd30 - f_w;      // t

    // N_k = V * (DIVK - S*k) (+ bias). S*k never exceeds DIVK, so the
    // difference stays non-negative and the product fits in 21 bits.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_num
            logic [15:0] sk_w;
            logic [15:0] diff_w;
            assign sk_w      = 16'(s_reg) * 16'(k_w[gi]);
            assign diff_w    = DIVK_16 - sk_w;
            assign num_w[gi] = 21'(24'(v_reg) * 24'(diff_w)) + BIAS;
        end
    endgenerate

    // ------------------------------------------------------------------
    // One restoring-divider step
    // ------------------------------------------------------------------
    logic [20:0] dsh_w;
    logic        ge_w;
    logic [20:0] rem_sub_w;
    logic [7:0]  qbit_w;
    logic [7:0]  q_cur_w;
    logic [20:0] rem_cur_w;

    assign dsh_w     = DIVK_21 << step_reg;   // at most 979200, fits 21 bits
    assign ge_w      = (rem_reg >= dsh_w);
    assign rem_sub_w = rem_reg - dsh_w;
    assign qbit_w    = 8'd1 << step_reg;
    assign q_cur_w   = ge_w ? (quot_reg | qbit_w) : quot_reg;
    assign rem_cur_w = ge_w ? rem_sub_w : rem_reg;

    // Next-state and datapath update; every register holds by default.
    always_comb begin
        state_next  = state_reg;
        h_next      = h_reg;
        s_next      = s_reg;
        v_next      = v_reg;
        sector_next = sector_reg;
        num_next    = num_reg;
        rem_next    = rem_reg;
        quot_next   = quot_reg;
        res_next    = res_reg;
        ch_next     = ch_reg;
        step_next   = step_reg;
        rgb_next    = rgb_reg;
        done_next   = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (enable) begin
                    h_next     = (HSV24[23:16] >= 8'd180) ? (HSV24[23:16] - 8'd180)
                                                          : HSV24[23:16];
                    s_next     = HSV24[15:8];
                    v_next     = HSV24[7:0];
                    state_next = S_LOAD;
                end
            end

            S_LOAD: begin
                sector_next = sec_w;
                for (int i = 0; i < 3; i++) begin
                    num_next[i] = num_w[i];
                end
                // Prime the divider with p so the first step runs next cycle.
                rem_next   = num_w[0];
                quot_next  = 8'd0;
                ch_next    = 2'd0;
                step_next  = 3'd7;
                state_next = S_DIV;
            end

            S_DIV: begin
                if (step_reg == 3'd0) begin
                    for (int i = 0; i < 3; i++) begin
                        if (ch_reg == 2'(i)) begin
                            res_next[i] = q_cur_w;
                        end
                    end
                    quot_next = 8'd0;
                    step_next = 3'd7;
                    if (ch_reg == 2'd2) begin
                        state_next = S_MAP;
                    end else begin
                        ch_next  = ch_reg + 2'd1;
                        rem_next = (ch_reg == 2'd0) ? num_reg[1] : num_reg[2];
                    end
                end else begin
                    step_next = step_reg - 3'd1;
                    rem_next  = rem_cur_w;
                    quot_next = q_cur_w;
                end
            end

            S_MAP: begin
                // res_reg[0]=p, [1]=q, [2]=t
                case (sector_reg)
                    3'd0:    rgb_next = {v_reg,      res_reg[2], res_reg[0]};
                    3'd1:    rgb_next = {res_reg[1], v_reg,      res_reg[0]};
                    3'd2:    rgb_next = {res_reg[0], v_reg,      res_reg[2]};
                    3'd3:    rgb_next = {res_reg[0], res_reg[1], v_reg};
                    3'd4:    rgb_next = {res_reg[2], res_reg[0], v_reg};
                    default: rgb_next = {v_reg,      res_reg[0], res_reg[1]};
                endcase
                done_next  = 1'b1;
                state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Register update; reset clears everything including any partial result.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= S_IDLE;
            h_reg      <= 8'd0;
            s_reg      <= 8'd0;
            v_reg      <= 8'd0;
            sector_reg <= 3'd0;
            for (int i = 0; i < 3; i++) begin
                num_reg[i] <= 21'd0;
                res_reg[i] <= 8'd0;
            end
            rem_reg    <= 21'd0;
            quot_reg   <= 8'd0;
            ch_reg     <= 2'd0;
            step_reg   <= 3'd0;
            rgb_reg    <= 24'd0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            h_reg      <= h_next;
            s_reg      <= s_next;
            v_reg      <= v_next;
            sector_reg <= sector_next;
            for (int i = 0; i < 3; i++) begin
                num_reg[i] <= num_next[i];
                res_reg[i] <= res_next[i];
            end
            rem_reg    <= rem_next;
            quot_reg   <= quot_next;
            ch_reg     <= ch_next;
            step_reg   <= step_next;
            rgb_reg    <= rgb_next;
            done_reg   <= done_next;
        end
    end

    assign RGB24    = rgb_reg;
    assign rgb_done = done_reg;
    assign busy     = (state_reg != S_IDLE);

endmodule

// File: tb/tb_hsv2rgb_clk.sv
// tb_hsv2rgb_clk - scoreboard bench for hsv2rgb_clk.
// Stimulus pushes the hand-computed RGB value and the cycle it must appear
// on into a queue; a negedge monitor pops and compares on every rgb_done.
// Expected values follow HSV2RGB_ROUND_EN when the macro is defined.
module tb_hsv2rgb_clk;

    logic        pclk;
    logic        rst_n;
    logic        enable;
    logic [23:0] HSV24;
    logic [23:0] RGB24;
    logic        rgb_done;
    logic        busy;

    hsv2rgb_clk dut (
        .pclk     (pclk),
        .rst_n    (rst_n),
        .enable   (enable),
        .HSV24    (HSV24),
        .RGB24    (RGB24),
        .rgb_done (rgb_done),
        .busy     (busy)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    typedef struct {
        logic [23:0] rgb;
        int          at_cyc;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    logic prev_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    task automatic push(input logic [23:0] rgb, input int at_cyc, input string name);
        exp_t e;
        e.rgb    = rgb;
        e.at_cyc = at_cyc;
        e.name   = name;
        exp_q.push_back(e);
    endtask

    // Entered just after a falling edge; waits for idle, strobes one pixel,
    // returns the accept edge number and leaves just after the next falling edge.
    task automatic send(input logic [23:0] hsv, input logic [23:0] exp_rgb,
                        input bit push_it, input string name, output int acc);
        int guard;
        guard = 0;
        acc   = -1;
        while (busy !== 1'b0 && guard < 100) begin
            @(negedge pclk);
            guard++;
        end
        if (busy !== 1'b0) begin
            checks++;
            $display("FAIL send_wait %s: busy=%b, required 0 within 100 cycles", name, busy);
            return;
        end
        enable = 1'b1;
        HSV24  = hsv;
        @(posedge pclk);
        #1;
        acc    = cyc;
        enable = 1'b0;
        HSV24  = 24'h5A5A5A;   // must not affect the conversion in flight
        if (push_it) push(exp_rgb, acc + 26, name);
        @(negedge pclk);
    endtask

    // Monitor: compare every presented result against the scoreboard.
    always @(negedge pclk) begin
        if (rgb_done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_done: rgb=%h at cycle %0d, required no output", RGB24, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("txn %-10s rgb=%h expected=%h cycle=%0d", e.name, RGB24, e.rgb, cyc);
                chk({e.name, "_rgb"},   32'(RGB24), 32'(e.rgb));
                chk({e.name, "_cycle"}, 32'(cyc),   32'(e.at_cyc));
                chk({e.name, "_busy"},  32'(busy),  32'd0);
            end
            chk("done_single_pulse", 32'(prev_done), 32'd0);
        end
        prev_done = rgb_done;
    end

    // Directed vectors: {H,S,V} and hand-computed RGB (floor / rounded).
    localparam int NV = 14;
    logic [23:0] vec_hsv [NV] = '{
        24'h00FFFF, 24'h3CFFFF, 24'h78FFFF, 24'h550080, 24'h2DFF00,
        24'h0FFFFF, 24'hC8FFFF, 24'h14FFFF, 24'hB3FFFF, 24'h28FFFF,
        24'h46FFFF, 24'h64FFFF, 24'h82FFFF, 24'h0A80C8
    };
`ifdef HSV2RGB_ROUND_EN
    logic [23:0] vec_rgb [NV] = '{
        24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h808080, 24'h000000,
        24'hFF8000, 24'hFFAA00, 24'hFFAA00, 24'hFF0009, 24'hAAFF00,
        24'h00FF55, 24'h00AAFF, 24'h5500FF, 24'hC88564
    };
`else
    logic [23:0] vec_rgb [NV] = '{
        24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h808080, 24'h000000,
        24'hFF7F00, 24'hFFAA00, 24'hFFAA00, 24'hFF0008, 24'hAAFF00,
        24'h00FF55, 24'h00AAFF, 24'h5500FF, 24'hC88563
    };
`endif
    string vec_name [NV] = '{
        "red", "green", "blue", "grey", "black",
        "round_h15", "wrap_h200", "h20", "h179", "sector1",
        "sector2", "sector3", "sector4", "mid_sv"
    };

    logic [23:0] held_vec [3] = '{24'h00FFFF, 24'h78FFFF, 24'h3CFFFF};
    logic [23:0] held_exp [3] = '{24'hFF0000, 24'h0000FF, 24'h00FF00};

    initial begin
        int acc_a;
        int acc_b;
        int guard;

        rst_n  = 1'b1;
        enable = 1'b0;
        HSV24  = 24'h000000;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_rgb",  32'(RGB24),    32'd0);
        chk("reset_done", 32'(rgb_done), 32'd0);
        chk("reset_busy", 32'(busy),     32'd0);
        repeat (3) @(negedge pclk);
        rst_n = 1'b1;
        @(negedge pclk);

        // Directed table, issued back to back.
        for (int i = 0; i < NV; i++) begin
            send(vec_hsv[i], vec_rgb[i], 1'b1, vec_name[i], acc_a);
        end

        // An enable pulse mid-conversion is ignored; the next one at k+27 is taken.
        send(24'h00FFFF, 24'hFF0000, 1'b1, "pulse_a", acc_a);
        repeat (4) @(negedge pclk);
        enable = 1'b1;
        HSV24  = 24'h78FFFF;
        @(posedge pclk);
        #1 enable = 1'b0;
        @(negedge pclk);
        send(24'h3CFFFF, 24'h00FF00, 1'b1, "pulse_b", acc_b);
        chk("back_to_back_accept", 32'(acc_b - acc_a), 32'd27);

        // enable held high: one accept every 27 cycles, inputs sampled only then.
        guard = 0;
        while (busy !== 1'b0 && guard < 100) begin
            @(negedge pclk);
            guard++;
        end
        enable = 1'b1;
        for (int n = 0; n <= 54; n++) begin
            HSV24 = (n % 27 == 0) ? held_vec[n / 27] : 24'h1E8040;
            @(posedge pclk);
            #1;
            if (n % 27 == 0) push(held_exp[n / 27], cyc + 26, "held");
            @(negedge pclk);
        end
        enable = 1'b0;

        // Reset in the middle of a conversion discards it immediately.
        send(24'h14FFFF, 24'hFFAA00, 1'b0, "aborted", acc_a);
        repeat (9) @(negedge pclk);
        @(posedge pclk);          // edge k+10
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_rgb",  32'(RGB24),    32'd0);
        chk("midreset_done", 32'(rgb_done), 32'd0);
        chk("midreset_busy", 32'(busy),     32'd0);
        @(negedge pclk);
        rst_n = 1'b1;
        send(24'h00FFFF, 24'hFF0000, 1'b1, "post_reset", acc_a);

        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(negedge pclk);
            guard++;
        end
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge pclk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
